// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the Datapath run/step controller: FSM state encoding.
package dp_ctrl_pkg;

  localparam int STATE_W = 2;

  // Encoding is visible on the State port, so the values are fixed.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } dp_state_t;

endpackage

// File: rtl/btn_edge.sv
// Push-button conditioner: two-flop synchronizer followed by a rising-edge
// detector, so a held button yields a single one-cycle request.
module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronize the raw button and remember the previous synchronized level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/datapath_run_ctrl.sv
// Run/step controller: turns Run/Step/Halt buttons into a one-cycle Datapath
// advance enable, with free-run pacing and an optional PC breakpoint.
module datapath_run_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RunBtn,
  input  logic        StepBtn,
  input  logic        HaltBtn,
  input  logic [31:0] PCResult,
  input  logic [31:0] Breakpoint,
  input  logic        BreakEn,
  output logic        DpEn,
  output logic [1:0]  State,
  output logic [31:0] StepCount,
  output logic        Halted
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic run_rise;
  logic step_rise;
  logic halt_rise;

  dp_state_t         state, state_nxt;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic              skip, skip_nxt;
  logic              dp_en_nxt;
  logic              terminal;
  logic              bp_hit;

  btn_edge u_run_edge  (.clk(Clk), .reset_n(Reset), .btn(RunBtn),  .rise(run_rise));
  btn_edge u_step_edge (.clk(Clk), .reset_n(Reset), .btn(StepBtn), .rise(step_rise));
  btn_edge u_halt_edge (.clk(Clk), .reset_n(Reset), .btn(HaltBtn), .rise(halt_rise));

  assign terminal = (tick == TICK_LAST);
  // skip lets the first terminal tick after a resume execute the breakpoint instruction.
  assign bp_hit   = BreakEn && (PCResult == Breakpoint) && !skip;

  // Next-state and pulse decision; button priority is Halt > Step > Run.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    skip_nxt  = skip;
    dp_en_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (halt_rise) begin
          state_nxt = IDLE;
        end else if (step_rise) begin
          state_nxt = STEP;
          dp_en_nxt = 1'b1;
        end else if (run_rise) begin
          state_nxt = RUN;
          tick_nxt  = '0;
        end
      end
      STEP: begin
        state_nxt = IDLE;
      end
      RUN: begin
        if (halt_rise) begin
          state_nxt = IDLE;
        end else if (step_rise) begin
          state_nxt = STEP;
          dp_en_nxt = 1'b1;
        end else if (terminal) begin
          tick_nxt = '0;
          skip_nxt = 1'b0;
          if (bp_hit) begin
            state_nxt = BREAK;
          end else begin
            dp_en_nxt = 1'b1;
          end
        end else begin
          tick_nxt = tick + TICK_W'(1);
        end
      end
      BREAK: begin
        if (halt_rise) begin
          state_nxt = IDLE;
        end else if (step_rise) begin
          state_nxt = STEP;
          dp_en_nxt = 1'b1;
        end else if (run_rise) begin
          state_nxt = RUN;
          tick_nxt  = '0;
          skip_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pacing counter, enable pulse and advance counter; reset overrides all.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      tick      <= '0;
      skip      <= 1'b0;
      DpEn      <= 1'b0;
      Halted    <= 1'b0;
      StepCount <= '0;
    end else begin
      state  <= state_nxt;
      tick   <= tick_nxt;
      skip   <= skip_nxt;
      DpEn   <= dp_en_nxt;
      Halted <= (state_nxt == BREAK);
      if (DpEn) begin
        StepCount <= StepCount + 32'd1;
      end
    end
  end

  assign State = state;

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Directed bench for datapath_run_ctrl with TICK_DIV = 4 and a simple PC model.
module tb_datapath_run_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        RunBtn = 1'b0;
  logic        StepBtn = 1'b0;
  logic        HaltBtn = 1'b0;
  logic [31:0] PCResult;
  logic [31:0] Breakpoint = 32'h0;
  logic        BreakEn = 1'b0;
  logic        DpEn;
  logic [1:0]  State;
  logic [31:0] StepCount;
  logic        Halted;

  logic [31:0] pc_model;
  int n_checks = 0;
  int n_errors = 0;

  datapath_run_ctrl #(.TICK_DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .RunBtn(RunBtn), .StepBtn(StepBtn), .HaltBtn(HaltBtn),
    .PCResult(PCResult), .Breakpoint(Breakpoint), .BreakEn(BreakEn),
    .DpEn(DpEn), .State(State), .StepCount(StepCount), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  // Datapath stand-in: PC advances by 4 on every enabled cycle.
  always @(posedge Clk) begin
    if (!Reset) pc_model <= 32'h0;
    else if (DpEn) pc_model <= pc_model + 32'd4;
  end
  assign PCResult = pc_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic cycles(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (DpEn) pulses++;
    end
  endtask

  // Buttons high for exactly one sampling edge.
  task automatic press(input logic r, input logic s, input logic h);
    RunBtn = r; StepBtn = s; HaltBtn = h;
    cyc();
    RunBtn = 1'b0; StepBtn = 1'b0; HaltBtn = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      cyc();
      if (State == s) ok = 1'b1;
    end
  endtask

  task automatic wait_pulse(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      cyc();
      if (DpEn) ok = 1'b1;
    end
  endtask

  initial begin
    int p, q, cnt, first, last, badgap;
    bit ok;

    // Reset held with buttons toggling.
    for (int i = 0; i < 3; i++) begin
      RunBtn = i[0]; StepBtn = ~i[0]; HaltBtn = i[0];
      cyc();
      check("rst_state", State, 2'b00);
      check("rst_dpen", DpEn, 1'b0);
      check("rst_count", StepCount, 32'd0);
      check("rst_halted", Halted, 1'b0);
    end
    RunBtn = 1'b0; StepBtn = 1'b0; HaltBtn = 1'b0;
    Reset = 1'b1;
    cycles(4, p);
    check("post_rst_pulses", p, 0);
    check("post_rst_state", State, 2'b00);

    // Single step: pulse between edges N+2 and N+3.
    press(0, 1, 0);
    cyc();
    check("step_n1_dpen", DpEn, 1'b0);
    cyc();
    check("step_n2_dpen", DpEn, 1'b1);
    check("step_n2_state", State, 2'b10);
    check("step_n2_count", StepCount, 32'd0);
    cyc();
    check("step_n3_dpen", DpEn, 1'b0);
    check("step_n3_state", State, 2'b00);
    check("step_n3_count", StepCount, 32'd1);

    // Held step button: one pulse only.
    StepBtn = 1'b1;
    cycles(10, p);
    StepBtn = 1'b0;
    cycles(4, q);
    check("hold_pulses", p + q, 1);
    check("hold_count", StepCount, 32'd2);

    // Free run: 5 pulses in 20 cycles, spaced 4 apart.
    press(1, 0, 0);
    cyc();
    cyc();
    check("run_state", State, 2'b01);
    cnt = 0; first = -1; last = -1; badgap = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (DpEn) begin
        if (first < 0) first = i;
        if (last >= 0 && (i - last) != 4) badgap++;
        last = i;
        cnt++;
      end
    end
    check("run_pulses", cnt, 5);
    check("run_first", first, 4);
    check("run_gaps", badgap, 0);

    // Halt stops the run.
    press(0, 0, 1);
    cycles(7, p);
    check("halt_pulses", p, 0);
    check("halt_state", State, 2'b00);
    check("halt_count", StepCount, 32'd7);

    // Breakpoint at 0xC.
    Reset = 1'b0;
    cyc();
    cyc();
    Reset = 1'b1;
    BreakEn = 1'b1;
    Breakpoint = 32'h0000_000C;
    check("bp_count0", StepCount, 32'd0);
    press(1, 0, 0);
    wait_state(2'b11, 40, ok);
    check("bp_reached", ok, 1'b1);
    check("bp_state", State, 2'b11);
    check("bp_halted", Halted, 1'b1);
    check("bp_count", StepCount, 32'd3);
    check("bp_pc", PCResult, 32'h0000_000C);
    check("bp_dpen", DpEn, 1'b0);
    cycles(6, p);
    check("bp_stays", p, 0);

    // Resume past the breakpoint.
    press(1, 0, 0);
    wait_pulse(20, ok);
    check("resume_pulse", ok, 1'b1);
    cyc();
    check("resume_pc", PCResult, 32'h0000_0010);
    check("resume_state", State, 2'b01);
    check("resume_halted", Halted, 1'b0);
    check("resume_count", StepCount, 32'd4);
    wait_pulse(10, ok);
    check("resume_next", ok, 1'b1);
    check("resume_run", State, 2'b01);

    // Halt and Run together while running: Halt wins.
    press(1, 0, 1);
    cycles(3, p);
    check("sim_hr_state", State, 2'b00);

    // Step and Run together while idle: Step wins, one pulse.
    press(1, 1, 0);
    cyc();
    cyc();
    check("sim_sr_state", State, 2'b10);
    check("sim_sr_dpen", DpEn, 1'b1);
    cycles(8, p);
    check("sim_sr_extra", p, 0);
    check("sim_sr_idle", State, 2'b00);
    check("sim_sr_count", StepCount, 32'd6);

    // Reset in the middle of a run pulse.
    press(1, 0, 0);
    wait_pulse(20, ok);
    check("mid_pulse_seen", ok, 1'b1);
    Reset = 1'b0;
    cyc();
    check("mid_dpen", DpEn, 1'b0);
    check("mid_count", StepCount, 32'd0);
    check("mid_state", State, 2'b00);
    check("mid_halted", Halted, 1'b0);
    Reset = 1'b1;
    cycles(12, p);
    check("mid_after_pulses", p, 0);
    check("mid_after_state", State, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/datapath_run_ctrl.md
# datapath_run_ctrl

Run/step controller for the pipelined Datapath on the board build. It turns three push-buttons into a one-cycle advance enable, `DpEn`, for the Datapath, so the processor can free-run at a visible rate, single-step, or stop. It can also halt automatically when `PCResult` reaches a breakpoint address. It sits in TopLevel between the buttons and the Datapath's clock-enable, beside the display driver.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: `Clk` cycles per Datapath advance in RUN; must be ≥ 2.

Ports:
- `Clk`  in  1  system clock; the only clock in the block.
- `Reset`  in  1  synchronous, active-low reset.
- `RunBtn`  in  1  raw asynchronous button; its rising edge requests RUN.
- `StepBtn`  in  1  raw asynchronous button; its rising edge requests one advance.
- `HaltBtn`  in  1  raw asynchronous button; its rising edge stops RUN or BREAK.
- `PCResult`  in  32  current PC from the Datapath.
- `Breakpoint`  in  32  breakpoint address.
- `BreakEn`  in  1  enables the breakpoint compare.
- `DpEn`  out  1  registered; high for exactly one cycle per Datapath advance.
- `State`  out  2  current FSM state.
- `StepCount`  out  32  count of `DpEn` pulses; wraps modulo 2^32.
- `Halted`  out  1  high while in BREAK.

## Operation
- Each button passes through a 2-flop synchronizer, then an edge detector: edge = sync2 & ~prev.
- Simultaneous edges are resolved by priority: Halt > Step > Run.

FSM states:
- IDLE = 2'b00
  - Step edge → STEP.
  - Run edge → RUN; `tick` is cleared.
- STEP = 2'b10
  - Lasts one cycle; `DpEn` is high during it.
  - Always returns to IDLE.
- RUN = 2'b01
  - `tick` counts 0 … TICK_DIV-1.
  - At `tick` == TICK_DIV-1: `tick` ← 0, and `DpEn` ← 1 unless a break fires.
  - Break fires when `BreakEn` && `PCResult` == `Breakpoint` && !`skip` → go to BREAK with no pulse. The instruction at the breakpoint is not executed.
  - Halt edge → IDLE.
  - Step edge → STEP.
- BREAK = 2'b11
  - Run edge → RUN, with `skip` ← 1. The first terminal tick after leaving BREAK ignores the compare; `skip` clears when that tick occurs.
  - Step edge → STEP; steps past the breakpoint.
  - Halt edge → IDLE.
- `StepCount` increments on every edge where `DpEn` == 1. It is cleared only by reset.
- `Halted` = (`State` == BREAK), registered together with the state.

## Timing
- Reset (`Reset` == 0 at an edge) sets: `State` = IDLE, `DpEn` = 0, `StepCount` = 0, `Halted` = 0, `tick` = 0, `skip` = 0, and all synchronizer/edge flops = 0.
- Reset wins over every other event, including mid-pulse: `DpEn` drops at that same edge.
- Button latency: input high at edge N → `sync1` at N, `sync2` at N+1, state register updated at N+2.
- Step latency: `DpEn` is high between edges N+2 and N+3. `State` is back to IDLE at N+3.
- RUN pulses: entering RUN at edge E gives the first `DpEn` high in the cycle after edge E+TICK_DIV, then one pulse every TICK_DIV cycles.
- Breakpoint compare uses `PCResult` as sampled in the terminal-tick cycle.
- A held button produces one edge only. A new edge needs at least one low sample first.

## Structure
- Package `dp_ctrl_pkg`: state encoding constants IDLE/RUN/STEP/BREAK and a `dp_state_t` typedef.
- Sub-module `btn_edge` (2-flop sync + edge detect, synchronous active-low reset), instantiated once per button.
- Top level holds the FSM, the `tick` counter, the `skip` flag, the `DpEn` register and `StepCount`.

## Test plan
All scenarios use `TICK_DIV` = 4.
- Reset: hold `Reset` = 0 for 3 cycles with buttons toggling → `State` = 00, `DpEn` = 0, `StepCount` = 0, `Halted` = 0 throughout.
- Step: `StepBtn` high for 1 cycle at edge N → `DpEn` high only in the cycle N+2..N+3; `StepCount` = 1; `State` = IDLE at N+3. Holding `StepBtn` for 10 cycles still gives exactly 1 pulse.
- Run/halt: Run edge, then 20 cycles → 5 `DpEn` pulses spaced 4 apart. Halt edge → no further pulses; `State` = IDLE.
- Breakpoint: `BreakEn` = 1, `Breakpoint` = 0x0000000C; the bench model advances `PCResult` by 4 from 0 on each `DpEn`. Run → pulses at PC 0, 4, 8, then `State` = BREAK, `Halted` = 1, `StepCount` = 3, `PCResult` = 0xC. Run again → next pulse is issued (PC → 0x10) and RUN continues.
- Simultaneous: Halt and Run edges in the same cycle while in RUN → IDLE. Step and Run in the same cycle while in IDLE → STEP, with a single pulse.
- Reset mid-pulse: `Reset` = 0 in the cycle `DpEn` = 1 during RUN → next edge shows `DpEn` = 0, `StepCount` = 0, `State` = IDLE. After release, no pulse occurs without a new Run edge.
